// File: rtl/wb_tgt_chk.sv
// wb_tgt_chk: passive Wishbone pipelined-target checker (outstanding count, response timeout, sticky violations + irq).
// Outputs registered (1-cycle latency); observes only, never stalls the bus; `WB_TGT_CHK_STABLE_EN adds the stall-stability check.
module wb_tgt_chk #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int MAX_OUT    = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = $clog2(MAX_OUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  tgt_cyc_o,
  input  logic                  tgt_stb_o,
  input  logic                  tgt_we_o,
  input  logic                  tgt_lock_o,
  input  logic [SEL_WIDTH-1:0]  tgt_sel_o,
  input  logic [ADR_WIDTH-1:0]  tgt_adr_o,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_o,
  input  logic [TGA_WIDTH-1:0]  tgt_tga_o,
  input  logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  input  logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  out_cnt_o,
  output logic [6:0]            viol_o,
  output logic                  irq_o
);

  localparam int TO_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUT);
  localparam logic [TO_WIDTH-1:0]  TO_MAX  = TO_WIDTH'(TIMEOUT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TO_WIDTH-1:0]  to_q, to_d;
  logic [6:0]           viol_q, viol_d;
  logic                 irq_q, irq_d;

  logic acc, rsp, multi_rsp, stb_no_cyc;
  logic rsp_no_req, cyc_drop, overflow, to_hit, unstable;
  logic [6:0] det;

  assign acc        = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
  assign rsp        = tgt_ack_i | tgt_err_i | tgt_rty_i;
  assign multi_rsp  = (tgt_ack_i & tgt_err_i) | (tgt_ack_i & tgt_rty_i) | (tgt_err_i & tgt_rty_i);
  assign stb_no_cyc = tgt_stb_o & ~tgt_cyc_o;

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tgt_cyc_o)  state_d = S_ACTIVE;
      S_ACTIVE: if (!tgt_cyc_o) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counter moves while cyc is high (covers the IDLE->ACTIVE edge too); a drop flushes it.
  always_comb begin
    cnt_d      = cnt_q;
    rsp_no_req = 1'b0;
    overflow   = 1'b0;
    cyc_drop   = 1'b0;
    if (tgt_cyc_o) begin
      if (acc && !rsp) begin
        if (cnt_q == CNT_MAX) overflow = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (rsp && !acc) begin
        if (cnt_q == '0) rsp_no_req = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
    end else begin
      rsp_no_req = rsp;
      if (state_q == S_ACTIVE) begin
        cyc_drop = (cnt_q != '0);
        cnt_d    = '0;
      end
    end
  end

  always_comb begin
    to_d = to_q;
    if ((TIMEOUT == 0) || (cnt_q == '0) || rsp || clr_i) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 1'b1;
    end
    to_hit = (TIMEOUT != 0) && (to_d == TO_MAX);
  end

`ifdef WB_TGT_CHK_STABLE_EN
  localparam int PL_WIDTH = 2 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

  logic [PL_WIDTH-1:0] pl, pl_q, pl_d;
  logic                stall_q, stall_d;

  assign pl = {tgt_we_o, tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o};

  // A cyc drop is not judged here; it is left to the outstanding-count check.
  always_comb begin
    stall_d  = tgt_cyc_o & tgt_stb_o & tgt_stall_i;
    pl_d     = pl;
    unstable = stall_q & tgt_cyc_o & (~tgt_stb_o | (pl != pl_q));
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      stall_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      stall_q <= stall_d;
      pl_q    <= pl_d;
    end
  end
`else
  logic unused_payload;

  assign unused_payload = ^{tgt_we_o, tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
                            tgt_tga_o, tgt_tgc_o, tgt_tgd_o};
  assign unstable       = 1'b0;
`endif

  assign det = {unstable, stb_no_cyc, to_hit, overflow, cyc_drop, multi_rsp, rsp_no_req};

  // A violation seen in the clear cycle survives the clear.
  always_comb begin
    viol_d = clr_i ? det : (viol_q | det);
    irq_d  = |(viol_d & ~viol_q);
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      cnt_q  <= '0;
      to_q   <= '0;
      viol_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      to_q   <= to_d;
      viol_q <= viol_d;
      irq_q  <= irq_d;
    end
  end

  assign out_cnt_o = cnt_q;
  assign viol_o    = viol_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_tgt_chk.sv
// Bench for wb_tgt_chk: directed vectors, per-cycle comparison against a behavioural model, plus literal checks.
module tb_wb_tgt_chk;

  localparam int MAXO = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 0, stb = 0, we = 0, lock = 0, ack = 0, err = 0, rty = 0, stall = 0, clr = 0;
  logic [1:0]  sel = 2'b11;
  logic [15:0] adr = '0, dat = '0;
  logic [0:0]  tga = '0, tgc = '0, tgd = '0;
  logic [2:0]  out_cnt;
  logic [6:0]  viol;
  logic        irq;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wb_tgt_chk #(.MAX_OUT(MAXO), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .async_rst_i(rst_n),
    .tgt_cyc_o(cyc), .tgt_stb_o(stb), .tgt_we_o(we), .tgt_lock_o(lock),
    .tgt_sel_o(sel), .tgt_adr_o(adr), .tgt_dat_o(dat),
    .tgt_tga_o(tga), .tgt_tgc_o(tgc), .tgt_tgd_o(tgd),
    .tgt_ack_i(ack), .tgt_err_i(err), .tgt_rty_i(rty), .tgt_stall_i(stall),
    .clr_i(clr), .out_cnt_o(out_cnt), .viol_o(viol), .irq_o(irq)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding count as a plain integer, clamped to [0, MAXO].
  int         m_cnt = 0, m_to = 0;
  bit         m_act = 0;
  logic [6:0] m_viol = '0;
  logic       m_irq = 1'b0;
  bit         m_stl = 0;
  logic [38:0] m_pl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_to = 0; m_act = 0; m_viol = '0; m_irq = 1'b0; m_stl = 0; m_pl = '0;
    end else begin
      logic [6:0] hit, nv;
      int nr, nxt;
      bit a;
      hit = '0;
      a   = cyc && stb && !stall;
      nr  = int'(ack) + int'(err) + int'(rty);
      if (nr > 1) hit[1] = 1'b1;
      if (stb && !cyc) hit[5] = 1'b1;
      if (m_cnt == 0 || nr > 0 || clr) m_to = 0;
      else if (m_to < TMO) m_to++;
      if (TMO > 0 && m_to == TMO) hit[4] = 1'b1;
      if (cyc) begin
        nxt = m_cnt + (a ? 1 : 0) - (nr > 0 ? 1 : 0);
        if (nxt < 0)    begin hit[0] = 1'b1; nxt = 0;    end
        if (nxt > MAXO) begin hit[3] = 1'b1; nxt = MAXO; end
        m_cnt = nxt;
      end else begin
        if (nr > 0) hit[0] = 1'b1;
        if (m_act && m_cnt > 0) hit[2] = 1'b1;
        m_cnt = 0;
      end
      m_act = cyc;
`ifdef WB_TGT_CHK_STABLE_EN
      if (m_stl && cyc && (!stb || m_pl != {we, lock, sel, adr, dat, tga, tgc, tgd})) hit[6] = 1'b1;
      m_stl = cyc && stb && stall;
      m_pl  = {we, lock, sel, adr, dat, tga, tgc, tgd};
`endif
      nv     = clr ? hit : (m_viol | hit);
      m_irq  = |(nv & ~m_viol);
      m_viol = nv;
    end
  end

  always @(negedge clk) begin
    chk("model_cnt", int'(out_cnt), m_cnt);
    chk("model_viol", int'(viol), int'(m_viol));
    chk("model_irq", int'(irq), int'(m_irq));
  end

  task automatic bus(input bit c, input bit s, input bit st, input bit a, input bit e,
                     input bit r, input bit cl, input logic [15:0] ad);
    cyc = c; stb = s; stall = st; ack = a; err = e; rty = r; clr = cl; adr = ad;
    @(negedge clk);
  endtask

  task automatic idle();
    bus(0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic clear();
    bus(0, 0, 0, 0, 0, 0, 1, 16'h0);
    chk("clr_viol", int'(viol), 0);
  endtask

`ifdef WB_TGT_CHK_STABLE_EN
  localparam int UNST_EXP = 'h40;
`else
  localparam int UNST_EXP = 'h00;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      cyc = 1'($urandom); stb = 1'($urandom); ack = 1'($urandom); err = 1'($urandom);
      rty = 1'($urandom); stall = 1'($urandom); adr = 16'($urandom);
      @(negedge clk);
      chk("rst_cnt", int'(out_cnt), 0);
      chk("rst_viol", int'(viol), 0);
      chk("rst_irq", int'(irq), 0);
    end
    cyc = 0; stb = 0; ack = 0; err = 0; rty = 0; stall = 0; adr = '0;
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 4; i++) begin
      bus(1, 1, 0, 0, 0, 0, 0, 16'(i));
      chk("burst_acc_cnt", int'(out_cnt), i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      bus(1, 0, 0, 1, 0, 0, 0, 16'h0);
      chk("burst_ack_cnt", int'(out_cnt), 3 - i);
    end
    chk("burst_viol", int'(viol), 0);
    idle();

    for (int i = 0; i < 5; i++) begin
      bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
      chk("ovf_cnt", int'(out_cnt), (i < 4) ? i + 1 : 4);
      chk("ovf_irq", int'(irq), (i == 4) ? 1 : 0);
    end
    chk("ovf_viol", int'(viol), 'h08);
    bus(1, 0, 0, 0, 0, 0, 1, 16'h0);
    chk("ovf_irq_once", int'(irq), 0);
    chk("ovf_clr", int'(viol), 0);
    for (int i = 0; i < 4; i++) bus(1, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("ovf_drain", int'(out_cnt), 0);
    idle();

    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      bus(1, 0, 0, 0, 0, 0, 0, 16'h0);
      if (i == 6) chk("to_before", int'(viol), 0);
    end
    chk("to_flag", int'(viol), 'h10);
    chk("to_irq", int'(irq), 1);
    bus(1, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("to_late_cnt", int'(out_cnt), 0);
    chk("to_sticky", int'(viol), 'h10);
    idle();
    clear();

    bus(1, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("rsp_no_req", int'(viol), 'h01);
    chk("rsp_no_req_irq", int'(irq), 1);
    bus(1, 0, 0, 0, 0, 0, 1, 16'h0);
    chk("rsp_no_req_clr", int'(viol), 0);
    idle();

    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    bus(1, 0, 0, 1, 1, 0, 0, 16'h0);
    chk("multi_rsp", int'(viol), 'h02);
    chk("multi_rsp_cnt", int'(out_cnt), 0);
    idle();
    clear();

    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("drop_pre_cnt", int'(out_cnt), 2);
    idle();
    chk("cyc_drop", int'(viol), 'h04);
    chk("cyc_drop_cnt", int'(out_cnt), 0);
    clear();

    bus(0, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("stb_no_cyc", int'(viol), 'h20);
    clear();

    bus(1, 1, 1, 0, 0, 0, 0, 16'h10);
    chk("stab_first", int'(viol), 0);
    bus(1, 1, 1, 0, 0, 0, 0, 16'h11);
    chk("stab_unstable", int'(viol), UNST_EXP);
    bus(1, 1, 0, 0, 0, 0, 0, 16'h11);
    chk("stab_acc_cnt", int'(out_cnt), 1);
    bus(1, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("stab_done_viol", int'(viol), UNST_EXP);
    idle();
    clear();

    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    bus(1, 1, 0, 0, 0, 0, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(out_cnt), 0);
    chk("arst_viol", int'(viol), 0);
    chk("arst_irq", int'(irq), 0);
    @(negedge clk);
    cyc = 0; stb = 0;
    rst_n = 1'b1;
    idle();
    idle();
    chk("arst_after_viol", int'(viol), 0);
    chk("arst_after_cnt", int'(out_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wb_tgt_chk.md
# wb_tgt_chk

Synthesizable checker for a pipelined Wishbone target interface. It tracks up to MAX_OUT outstanding accepted requests, times out missing responses, and records protocol violations in sticky flags with an interrupt pulse. It sits passively beside any target port (crossbar output, bridge input) and drives no bus signals, so it can stay in silicon, unlike the assertion-only monitors.

## Interface
Parameters:
- ADR_WIDTH, 16, address bus width
- DAT_WIDTH, 16, data bus width
- SEL_WIDTH, 2, select lines
- TGA_WIDTH, 1, address tags
- TGC_WIDTH, 1, cycle tags
- TGWD_WIDTH, 1, write data tags
- MAX_OUT, 4, max outstanding accepted requests (≥1)
- TIMEOUT, 256, cycles without response before timeout; 0 disables
- CNT_WIDTH, $clog2(MAX_OUT+1), outstanding counter width (derived)

Ports:
- clk_i  in  1  module clock
- async_rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o  in  1 each  observed initiator controls
- tgt_sel_o  in  SEL_WIDTH  observed selects
- tgt_adr_o  in  ADR_WIDTH  observed address
- tgt_dat_o  in  DAT_WIDTH  observed write data
- tgt_tga_o / tgt_tgc_o / tgt_tgd_o  in  TGA/TGC/TGWD_WIDTH  observed tags
- tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each  observed target responses
- clr_i  in  1  synchronous clear of viol_o and timeout counter
- out_cnt_o  out  CNT_WIDTH  current outstanding count
- viol_o  out  7  sticky violation flags
- irq_o  out  1  one-cycle pulse on any new flag

## Operation
- Abbreviations: acc = cyc & stb & ~stall; rsp = ack | err | rty.
- FSM, 2 states:
  - IDLE (reset): when cyc=1, go to ACTIVE.
  - ACTIVE: when cyc=0, go to IDLE. If out_cnt>0 at that edge, set CYC_DROP and clear the counter to 0.
- Counter, in ACTIVE or on the IDLE→ACTIVE edge: next = cnt + acc − rsp.
  - acc and rsp in the same cycle: cnt unchanged.
  - rsp with cnt=0 and no acc: set RSP_NO_REQ; cnt stays 0.
  - acc with cnt=MAX_OUT and no rsp: set OVERFLOW; cnt saturates at MAX_OUT.
  - rsp while cyc=0: set RSP_NO_REQ; counter untouched.
- Timeout counter, width $clog2(TIMEOUT+1):
  - Cleared when cnt=0, on rsp, or on clr_i.
  - Otherwise increments, saturating at TIMEOUT.
  - Reaching TIMEOUT sets TIMEOUT; it stays set until clr_i.
- viol_o bits:
  - [0] RSP_NO_REQ
  - [1] MULTI_RSP: more than one of ack/err/rty high
  - [2] CYC_DROP
  - [3] OVERFLOW
  - [4] TIMEOUT
  - [5] STB_NO_CYC: stb=1 with cyc=0
  - [6] UNSTABLE: see Configuration
- Flags are sticky. clr_i clears all flags. A violation detected in the same cycle as clr_i wins, so that bit is set.
- irq_o = |(viol_next & ~viol_reg), registered.

## Timing
- Reset values: FSM=IDLE, out_cnt_o=0, viol_o=0, irq_o=0, timeout counter=0, stability shadow registers=0.
- All outputs are registered. A violation sampled at edge n is visible on viol_o and irq_o after edge n. irq_o is high for exactly one cycle per newly set bit set.
- out_cnt_o reflects acc/rsp sampled at the previous edge (latency 1).
- Asserting async_rst_i mid-transaction returns all state to reset values immediately. No flag is raised on deassertion.

## Configuration
- WB_TGT_CHK_STABLE_EN defined:
  - Registers cyc&stb&stall plus we, lock, sel, adr, dat, tga, tgc, tgd.
  - If the previous cycle was stalled (cyc&stb&stall) and the current cycle has stb=0 or any payload field differs, set viol_o[6].
  - A cyc drop does not set UNSTABLE; it is handled as CYC_DROP if requests are outstanding.
- Not defined: no shadow registers; viol_o[6] is tied to 0.

## Test plan
- Reset: hold async_rst_i=0 with random bus activity → out_cnt_o=0, viol_o=0, irq_o=0 throughout.
- Pipelined burst, MAX_OUT=4: 4 back-to-back acc, then 4 acks one per cycle → out_cnt_o goes 1,2,3,4,3,2,1,0; viol_o=0.
- Overflow: 5 acc with no ack, MAX_OUT=4 → out_cnt_o=4, viol_o=7'h08, irq_o pulses once. Then clr_i=1 → viol_o=0.
- Timeout, TIMEOUT=8: 1 acc, no response → viol_o[4]=1 after the 8th idle cycle. A late ack then gives out_cnt_o=0 and the flag stays set.
- Misc: ack with cnt=0 → 7'h01; ack&err together → 7'h02; cyc drop with cnt=2 → 7'h04 and out_cnt_o=0; stb without cyc → 7'h20.
- Stability, macro defined: stb=1, stall=1, adr changes 0x10→0x11 → viol_o[6]=1. Repeat without the macro → viol_o[6]=0.
